// File: rtl/top_mul_share_pkg.sv
// Shared widths and result type for the time-shared multiplier scheduler.
// Default sizes match the HLS dataflow instance; the top may override them.
package top_mul_share_pkg;

    localparam int NREQ_DEF = 4;
    localparam int A_W_DEF  = 9;
    localparam int B_W_DEF  = 2;
    localparam int P_W_DEF  = 9;

    // A single requester still needs a one-bit id field.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int RES_ID_W = id_width(NREQ_DEF);

    typedef struct packed {
        logic [P_W_DEF-1:0]  data;
        logic [RES_ID_W-1:0] id;
    } res_t;

endpackage

// File: rtl/mul_9s_2ns.sv
// Existing combinational 9-bit signed x 2-bit unsigned multiplier core.
// B is zero-extended to a positive signed value; only the low P_W bits are kept.
module mul_9s_2ns #(
    parameter int A_W = 9,
    parameter int B_W = 2,
    parameter int P_W = 9
) (
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic [P_W-1:0] p
);

    localparam int F_W = A_W + B_W + 1;

    logic signed [F_W-1:0] a_x;
    logic signed [F_W-1:0] b_x;

    assign a_x = F_W'($signed(a));
    assign b_x = F_W'({1'b0, b});
    assign p   = P_W'(a_x * b_x);

endmodule

// File: rtl/top_sched_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr,
// searching upward with wrap-around.
module top_sched_rr_pick #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(rr_ptr) + k) % NREQ;
            if (!any && req[j]) begin
                grant[j] = 1'b1;
                idx      = ID_W'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/top_mul_share_sched.sv
// Shares one multiplier core among NREQ valid/ready requesters through a
// two-stage pipeline (operand register S1, result register S2), round-robin.
module top_mul_share_sched
    import top_mul_share_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int A_W  = A_W_DEF,
    parameter int B_W  = B_W_DEF,
    parameter int P_W  = P_W_DEF,
    localparam int ID_W = id_width(NREQ)
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*A_W-1:0] req_a,
    input  logic [NREQ*B_W-1:0] req_b,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [P_W-1:0]      res_data,
    output logic [ID_W-1:0]     res_id,
    output logic                busy
);

    // Handshake rule on every channel: a transfer happens on the rising edge
    // where valid and ready are both high; valid must not depend on ready.

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NREQ - 1);

    logic [ID_W-1:0] rr_ptr;
    logic [A_W-1:0]  op_a;
    logic [B_W-1:0]  op_b;
    logic [ID_W-1:0] op_id;
    logic            s1_valid;

    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] gnt_idx;
    logic            gnt_any;
    logic [P_W-1:0]  mul_p;

    logic out_en;
    logic s1_adv;
    logic acc_en;
    logic hs;

    assign out_en = !res_valid || res_ready;
    assign s1_adv = s1_valid && out_en;
    assign acc_en = !s1_valid || out_en;
    assign hs     = gnt_any && acc_en;
    assign busy   = s1_valid || res_valid;

    // Gated by reset so no requester sees ready while the block is held.
    assign req_ready = grant & {NREQ{acc_en && !ap_rst}};

    top_sched_rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .grant  (grant),
        .idx    (gnt_idx),
        .any    (gnt_any)
    );

    mul_9s_2ns #(
        .A_W (A_W),
        .B_W (B_W),
        .P_W (P_W)
    ) u_mul (
        .a (op_a),
        .b (op_b),
        .p (mul_p)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            op_a     <= '0;
            op_b     <= '0;
            op_id    <= '0;
            s1_valid <= 1'b0;
            rr_ptr   <= '0;
        end else if (hs) begin
            op_a     <= req_a[int'(gnt_idx)*A_W +: A_W];
            op_b     <= req_b[int'(gnt_idx)*B_W +: B_W];
            op_id    <= gnt_idx;
            s1_valid <= 1'b1;
            rr_ptr   <= (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Result register keeps its last data/id whenever nothing new is loaded.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            res_data  <= '0;
            res_id    <= '0;
            res_valid <= 1'b0;
        end else if (s1_adv) begin
            res_data  <= mul_p;
            res_id    <= op_id;
            res_valid <= 1'b1;
        end else if (out_en) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_top_mul_share_sched.sv
// Randomised scoreboard bench for top_mul_share_sched: a reference arbiter and
// arithmetic model predict each result; a negedge monitor pops and compares.
module tb_top_mul_share_sched;
    import top_mul_share_pkg::*;

    localparam int NREQ = 4;
    localparam int A_W  = 9;
    localparam int B_W  = 2;
    localparam int P_W  = 9;
    localparam int ID_W = 2;

    logic                ap_clk;
    logic                ap_rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*A_W-1:0] req_a;
    logic [NREQ*B_W-1:0] req_b;
    logic                res_valid;
    logic                res_ready;
    logic [P_W-1:0]      res_data;
    logic [ID_W-1:0]     res_id;
    logic                busy;

    top_mul_share_sched #(
        .NREQ (NREQ), .A_W (A_W), .B_W (B_W), .P_W (P_W)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    int cyc = 0;
    initial forever begin
        @(posedge ap_clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [$bits(res_t)-1:0] exp_q[$];
    int              exp_t[$];
    int              gnt_log[$];
    int              errors = 0;
    int              checks = 0;
    int              m_ptr = 0;
    int              res_count = 0;
    bit              mon_en = 0;
    bit              lat_chk = 0;
    bit              prev_stall = 0;
    logic [P_W+ID_W-1:0] prev_val;
    logic [P_W-1:0]  last_data;
    logic [ID_W-1:0] last_id;
    logic [NREQ-1:0] hs_flag = '0;
    logic [NREQ-1:0] auto_mask = '0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    // Reference: sign-interpret a, multiply by unsigned b, keep low P_W bits.
    function automatic logic [P_W-1:0] ref_mul(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        int av;
        int p;
        av = a[A_W-1] ? int'(a) - (1 << A_W) : int'(a);
        p  = av * int'(b);
        return P_W'(p);
    endfunction

    // Reference arbiter: first valid requester scanning up from ptr with wrap.
    function automatic int ref_pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // ---------------- monitor ----------------
    initial forever begin
        @(negedge ap_clk);
        if (mon_en && !ap_rst) begin
            if (res_valid && res_ready) begin
                res_count++;
                last_data = res_data;
                last_id   = res_id;
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    res_t e;
                    int   t;
                    e = exp_q.pop_front();
                    t = exp_t.pop_front();
                    check("res_data", int'(res_data), int'(e.data));
                    check("res_id", int'(res_id), int'(e.id));
                    if (lat_chk) check("latency", cyc - t, 2);
                end
            end
            if (prev_stall && res_valid && !res_ready)
                check("hold_data_id", int'({res_data, res_id}), int'(prev_val));
            prev_stall = res_valid && !res_ready;
            prev_val   = {res_data, res_id};

            hs_flag = req_valid & req_ready;
            if (req_ready != '0) check("ready_onehot", $countones(req_ready), 1);
            if (hs_flag != '0) begin
                res_t e;
                int   idx;
                idx = 0;
                for (int i = 0; i < NREQ; i++) if (hs_flag[i]) idx = i;
                check("grant_idx", idx, ref_pick(req_valid, m_ptr));
                e.data = ref_mul(req_a[idx*A_W +: A_W], req_b[idx*B_W +: B_W]);
                e.id   = ID_W'(idx);
                exp_q.push_back(e);
                exp_t.push_back(cyc);
                gnt_log.push_back(idx);
                m_ptr = (idx + 1) % NREQ;
            end
        end else begin
            hs_flag    = '0;
            prev_stall = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input int i, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        req_a[i*A_W +: A_W] = a;
        req_b[i*B_W +: B_W] = b;
        req_valid[i]        = 1'b1;
    endtask

    task automatic rand_issue(input int i);
        issue(i, A_W'($urandom), B_W'($urandom));
    endtask

    // One clock: retire accepted operands, refilling those under auto_mask.
    task automatic step();
        @(posedge ap_clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (hs_flag[i]) begin
                if (auto_mask[i]) rand_issue(i);
                else req_valid[i] = 1'b0;
            end
        end
        hs_flag = '0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || req_valid != '0 || busy) && n < budget) begin
            step();
            n++;
        end
        check("drain_timeout", int'(n < budget), 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int rc0;
        ap_rst    = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
        repeat (2) @(posedge ap_clk);
        #1;
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_res_data", int'(res_data), 0);
        check("rst_res_id", int'(res_id), 0);
        req_valid = '0;
        ap_rst    = 1'b0;
        res_ready = 1'b1;
        mon_en    = 1;
        lat_chk   = 1;

        // Directed single op and wrap-around products.
        issue(0, 9'h1FB, 2'd3);
        wait_idle(20);
        check("single_data", int'(last_data), 'h1F1);
        check("single_id", int'(last_id), 0);
        issue(1, 9'd255, 2'd3);
        wait_idle(20);
        check("wrap_255x3", int'(last_data), 'h0FD);
        issue(2, 9'h100, 2'd2);
        wait_idle(20);
        check("wrap_m256x2", int'(last_data), 0);
        issue(3, 9'd7, 2'd0);
        wait_idle(20);
        check("mul_by_zero", int'(last_data), 0);

        // All requesters continuously valid from rr_ptr=0.
        gnt_log.delete();
        auto_mask = '1;
        for (int i = 0; i < NREQ; i++) rand_issue(i);
        repeat (10) step();
        rc0 = res_count;
        repeat (30) step();
        check("throughput", res_count - rc0, 30);
        for (int k = 0; k < 8; k++) check("rr_order", gnt_log[k], k % NREQ);
        auto_mask = '0;
        wait_idle(40);

        // Backpressure: both stages fill, requesters stall, nothing lost.
        lat_chk   = 0;
        res_ready = 1'b0;
        auto_mask = 4'b0111;
        for (int i = 0; i < 3; i++) rand_issue(i);
        repeat (5) step();
        check("stall_inflight", exp_q.size(), 2);
        check("stall_req_ready", int'(req_ready), 0);
        res_ready = 1'b1;
        repeat (12) step();
        auto_mask = '0;
        wait_idle(40);

        // Requester 2 alone, then 1 joins: 1 must win after 2's handshake.
        lat_chk = 1;
        gnt_log.delete();
        auto_mask = 4'b0110;
        rand_issue(2);
        step();
        rand_issue(1);
        repeat (6) step();
        check("join_first", gnt_log[0], 2);
        check("join_second", gnt_log[1], 1);
        check("join_third", gnt_log[2], 2);
        auto_mask = '0;
        wait_idle(40);

        // Asynchronous reset with both stages full.
        res_ready = 1'b0;
        auto_mask = 4'b0111;
        for (int i = 0; i < 3; i++) rand_issue(i);
        repeat (4) step();
        check("pre_rst_busy", int'(busy), 1);
        #2;
        mon_en = 0;
        ap_rst = 1'b1;
        #1;
        check("arst_res_valid", int'(res_valid), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_req_ready", int'(req_ready), 0);
        exp_q.delete();
        exp_t.delete();
        m_ptr     = 0;
        auto_mask = '0;
        req_valid = '0;
        repeat (2) step();
        ap_rst    = 1'b0;
        res_ready = 1'b1;
        mon_en    = 1;
        issue(2, 9'h1FB, 2'd2);
        wait_idle(20);
        check("post_rst_data", int'(last_data), 'h1F6);
        check("post_rst_id", int'(last_id), 2);

        // Random traffic with random backpressure.
        lat_chk = 0;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 15) == 0) auto_mask = NREQ'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++)
                if (auto_mask[i] && !req_valid[i]) rand_issue(i);
            step();
        end
        auto_mask = '0;
        res_ready = 1'b1;
        wait_idle(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
